ndn_face_mux: RTL
=================

// Module: ndn_face_mux
// PURPOSE
//  Parametrised multi-face front end for the NDN router core. Replaces the single SPI link with NUM_FACES
//  byte-stream faces. Ingress: whole-packet round-robin arbitration onto one tagged stream for PIT/FIB
//  lookup, with oversize truncation. Egress: one forwarded stream is fanned out to a face mask (multicast
//  of Data to every face recorded in the PIT entry).
// PARAMETERS
//  NUM_FACES  4   number of faces (2..16)
//  DATA_W     8   bytes-per-beat width (bits)
//  MAX_LEN    64  max packet length in beats; longer packets are truncated
//  FACE_W     $clog2(NUM_FACES)  face-ID width (derived localparam)
// PORTS
//  clk           in   1                  system clock
//  rst           in   1                  async reset, active-low
//  in_valid      in   NUM_FACES          per-face ingress beat valid
//  in_data       in   NUM_FACES*DATA_W   per-face ingress byte, face i at [i*DATA_W +: DATA_W]
//  in_last       in   NUM_FACES          per-face last beat of packet
//  in_ready      out  NUM_FACES          per-face ingress accept
//  out_valid     out  1                  arbitrated stream valid (to PIT/FIB)
//  out_data      out  DATA_W             arbitrated byte
//  out_last      out  1                  last beat (real or forced by truncation)
//  out_face      out  FACE_W             ingress face ID of current packet
//  out_ready     in   1                  downstream accept
//  err_oversize  out  1                  1-cycle pulse when a packet is truncated
//  fwd_valid     in   1                  egress beat valid (from FIB/PIT)
//  fwd_data      in   DATA_W             egress byte
//  fwd_last      in   1                  egress last beat (passed through)
//  fwd_mask      in   NUM_FACES          destination faces, held stable for the whole packet
//  fwd_ready     out  1                  egress accept = AND of eg_ready over masked faces
//  eg_valid      out  NUM_FACES          per-face egress valid = fwd_valid & fwd_mask[i]
//  eg_data       out  DATA_W             egress byte, shared by all faces
//  eg_last       out  1                  egress last, shared by all faces
//  eg_ready      in   NUM_FACES          per-face egress accept; must not depend on eg_valid
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, grant=0, rr_ptr=NUM_FACES-1, beat_cnt=0; out_valid=0, in_ready=0,
//   out_last=0, out_face=0, err_oversize=0. A packet in flight is abandoned; no partial resume.
//  Beat transfer = valid & ready on the same rising edge.
//  FSM IDLE: all in_ready=0, out_valid=0. If any in_valid, grant <= first requesting face searching
//   rr_ptr+1, rr_ptr+2, ... (mod NUM_FACES); rr_ptr <= grant; beat_cnt <= 0; -> FWD. One bubble cycle.
//  FSM FWD: zero-latency pass-through of granted face g: out_valid=in_valid[g], out_data=in_data[g],
//   out_face=g, in_ready[g]=out_ready, all other in_ready=0. Each transfer increments beat_cnt.
//   - Transfer with in_last[g]=1 -> IDLE.
//   - Transfer at beat_cnt==MAX_LEN-1 with in_last[g]=0: out_last forced 1, err_oversize=1 next cycle,
//     -> DROP.
//  FSM DROP: out_valid=0, in_ready[g]=1; discards face g beats until in_last[g] is accepted -> IDLE.
//  A packet of exactly MAX_LEN beats with last on beat MAX_LEN is not truncated.
//  Face keeps grant only for one packet; a face requesting in the same cycle it finishes re-enters
//   arbitration behind other requesters (strict rotation, no starvation).
//  beat_cnt width $clog2(MAX_LEN+1); never wraps in FWD.
//  Egress is combinational, no state: fwd_ready = &(eg_ready | ~fwd_mask); fwd_mask==0 -> fwd_ready=1
//   and the beat is discarded. A beat completes on all masked faces in the same cycle.
// CONFIGURATION
//  NDN_FACE_STATS_EN defined: adds inputs stat_sel[FACE_W] and stat_clr, output stat_pkts[16]. Per-face
//   16-bit saturating counters of completed ingress packets (incl. truncated ones) increment on the
//   FWD->IDLE/DROP transition. stat_pkts=count[stat_sel], registered, 1-cycle latency. stat_clr
//   zeroes all counters. Reset clears all counters.
//  Not defined: ports, counters and logic absent; behaviour otherwise identical.
// TESTING
//  1 Face 2 sends 3 beats 0xA1,0xA2,0xA3(last), out_ready=1 -> one bubble, then 3 out beats,
//    out_face=2, in_ready[2] high 3 cycles.
//  2 Faces 0,1,3 all valid continuously with 2-beat packets -> grant order 0,1,3,0,1,3, no face twice
//    in a row.
//  3 Face 1 sends 70 beats, MAX_LEN=64 -> 64 out beats, 64th has out_last=1, err_oversize pulse,
//    beats 65-70 accepted and dropped, then IDLE.
//  4 out_ready toggles 1/0 mid-packet -> in_ready[g] mirrors it, no lost or duplicated bytes.
//  5 fwd_mask=4'b0101, eg_ready[2]=0 for 3 cycles -> fwd_ready=0, then beat lands on faces 0 and 2
//    together; fwd_mask=0 -> fwd_ready=1.
//  6 rst=0 asserted mid-FWD -> outputs zero at once; after release, face 0 wins first.
//    STATS_EN: 5 pkts on face 3 -> stat_pkts=5.

Source files
------------

// File: rtl/ndn_face_mux.sv
// ndn_face_mux: NUM_FACES byte-stream faces merged into one packet-granular round-robin stream,
// plus a stateless multicast egress fan-out. Define NDN_FACE_STATS_EN for per-face packet counters.
module ndn_face_mux #(
  parameter int NUM_FACES = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_LEN   = 64,
  localparam int FACE_W   = $clog2(NUM_FACES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FACES-1:0]        in_valid,
  input  logic [NUM_FACES*DATA_W-1:0] in_data,
  input  logic [NUM_FACES-1:0]        in_last,
  output logic [NUM_FACES-1:0]        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic [FACE_W-1:0]           out_face,
  input  logic                        out_ready,
  output logic                        err_oversize,
`ifdef NDN_FACE_STATS_EN
  input  logic [FACE_W-1:0]           stat_sel,
  input  logic                        stat_clr,
  output logic [15:0]                 stat_pkts,
`endif
  input  logic                        fwd_valid,
  input  logic [DATA_W-1:0]           fwd_data,
  input  logic                        fwd_last,
  input  logic [NUM_FACES-1:0]        fwd_mask,
  output logic                        fwd_ready,
  output logic [NUM_FACES-1:0]        eg_valid,
  output logic [DATA_W-1:0]           eg_data,
  output logic                        eg_last,
  input  logic [NUM_FACES-1:0]        eg_ready
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = FACE_W + 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t              state_reg;
  logic [FACE_W-1:0]   grant_reg;
  logic [FACE_W-1:0]   rr_ptr_reg;
  logic [CNT_W-1:0]    beat_cnt_reg;
  logic                err_oversize_reg;

  logic [FACE_W-1:0]   pick;
  logic [IDX_W-1:0]    idx;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                at_max;
  logic                xfer;

  assign g_valid = in_valid[grant_reg];
  assign g_last  = in_last[grant_reg];
  assign g_data  = in_data[grant_reg*DATA_W +: DATA_W];
  assign at_max  = (beat_cnt_reg == CNT_W'(MAX_LEN - 1));

  assign out_valid    = (state_reg == FWD) && g_valid;
  assign out_data     = (state_reg == FWD) ? g_data : '0;
  assign out_last     = out_valid && (g_last || at_max);
  assign out_face     = grant_reg;
  assign err_oversize = err_oversize_reg;
  assign xfer         = out_valid && out_ready;

  // Scan from the far end so the nearest requester after rr_ptr is the final assignment.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NUM_FACES; k >= 1; k--) begin
      idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
      if (idx >= IDX_W'(NUM_FACES))
        idx = idx - IDX_W'(NUM_FACES);
      if (in_valid[idx[FACE_W-1:0]])
        pick = idx[FACE_W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FACES; gi++) begin : g_rdy
      assign in_ready[gi] = (grant_reg == FACE_W'(gi)) &&
                            (((state_reg == FWD) && out_ready) || (state_reg == DROP));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      rr_ptr_reg       <= FACE_W'(NUM_FACES - 1);
      beat_cnt_reg     <= '0;
      err_oversize_reg <= 1'b0;
    end else begin
      err_oversize_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|in_valid) begin
            grant_reg    <= pick;
            rr_ptr_reg   <= pick;
            beat_cnt_reg <= '0;
            state_reg    <= FWD;
          end
        end
        FWD: begin
          if (xfer) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (g_last) begin
              state_reg <= IDLE;
            end else if (at_max) begin
              state_reg        <= DROP;
              err_oversize_reg <= 1'b1;
            end
          end
        end
        DROP: begin
          if (g_valid && g_last)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Egress fan-out: a beat completes only when every addressed face takes it together.
  assign eg_valid  = fwd_mask & {NUM_FACES{fwd_valid}};
  assign eg_data   = fwd_data;
  assign eg_last   = fwd_last;
  assign fwd_ready = &(eg_ready | ~fwd_mask);

`ifdef NDN_FACE_STATS_EN
  logic                        pkt_done;
  logic [NUM_FACES-1:0][15:0]  cnt_vec;
  logic [15:0]                 stat_pkts_reg;

  assign pkt_done  = xfer && (g_last || at_max);
  assign stat_pkts = stat_pkts_reg;

  generate
    for (gi = 0; gi < NUM_FACES; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          cnt_reg <= '0;
        else if (stat_clr)
          cnt_reg <= '0;
        else if (pkt_done && (grant_reg == FACE_W'(gi)) && (cnt_reg != 16'hFFFF))
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stat_pkts_reg <= '0;
    else
      stat_pkts_reg <= cnt_vec[stat_sel];
  end
`endif

endmodule
